// File: rtl/dcache_nway_if.sv
// Bus bundle for dcache_nway.
// Groups the datapath request port and the memory-controller data channel.
//   slave  : cache side (takes datapath requests and memory responses,
//            drives hit/load/flushed and memory requests)
//   master : environment side (datapath plus memory controller)
// Signals:
//   halt, dmemREN, dmemWEN, dmemaddr, dmemstore : datapath request
//   dhit, dmemload, flushed                     : datapath response
//   dREN, dWEN, daddr, dstore                   : memory request
//   dload, dwait                                : memory response
interface dcache_nway_if;
  logic        halt;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;

  modport slave (
    input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  modport master (
    output halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_nway.sv
// dcache_nway: N-way set-associative, write-back, write-allocate L1 data
// cache with per-set LRU ages (invalid ways filled first), a hit counter and
// a halt-triggered flush that writes back dirty lines and then stores the
// hit count at HITCNT_ADDR before raising flushed.
// Ports:
//   CLK   : clock
//   nRST  : asynchronous active-low reset
//   dcif  : dcache_nway_if.slave (datapath request/response and memory channel)
module dcache_nway #(
  parameter int          WAYS        = 2,
  parameter int          SETS        = 8,
  parameter int          BLOCK_WORDS = 2,
  parameter logic [31:0] HITCNT_ADDR = 32'h3100
) (
  input logic          CLK,
  input logic          nRST,
  dcache_nway_if.slave dcif
);
  localparam int BO = $clog2(BLOCK_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - BO - IW;
  localparam int WW = (BO > 0) ? BO : 1;
  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    COMPARE, WB, ALLOC, FLUSH_SCAN, FLUSH_WB, FLUSH_CNT, DONE
  } state_t;

  state_t          state;
  logic            valid [WAYS][SETS];
  logic            dirty [WAYS][SETS];
  logic [TW-1:0]   tags  [WAYS][SETS];
  logic [AW-1:0]   age   [WAYS][SETS];
  logic [31:0]     data  [WAYS][SETS][BLOCK_WORDS];

  logic [WW-1:0]   k;
  logic [AW-1:0]   vway;
  logic [TW-1:0]   mtag;
  logic [IW-1:0]   midx;
  logic [AW-1:0]   fway;
  logic [IW-1:0]   fset;
  logic            miss;
  logic [31:0]     hitcnt;

  logic [TW-1:0]   req_tag;
  logic [IW-1:0]   req_idx;
  logic [WW-1:0]   req_off;
  logic            req;
  logic            hit_any;
  logic [AW-1:0]   hit_way;
  logic [AW-1:0]   vic;
  logic            inv_found;
  logic            last_k;
  logic            last_line;
  logic            unused_bits;

  assign req_tag     = dcif.dmemaddr[31 -: TW];
  assign req_idx     = dcif.dmemaddr[2+BO +: IW];
  assign req_off     = (BO > 0) ? dcif.dmemaddr[2 +: WW] : '0;
  assign req         = dcif.dmemREN | dcif.dmemWEN;
  assign unused_bits = &{1'b0, dcif.dmemaddr[1:0]};
  assign last_k      = (k == WW'(BLOCK_WORDS - 1));
  assign last_line   = (fway == AW'(WAYS - 1)) && (fset == IW'(SETS - 1));
  assign dcif.flushed = (state == DONE);

  function automatic logic [31:0] mk_addr(input logic [TW-1:0] t,
                                          input logic [IW-1:0] i,
                                          input logic [WW-1:0] w);
    logic [31:0] a;
    a = (32'(t) << (2 + BO + IW)) | (32'(i) << (2 + BO));
    if (BO > 0) a = a | (32'(w) << 2);
    return a;
  endfunction

  // Tag match and victim choice: lowest invalid way, else the oldest way.
  always_comb begin
    hit_any   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    vic       = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_any && valid[AW'(w)][req_idx] && tags[AW'(w)][req_idx] == req_tag) begin
        hit_any = 1'b1;
        hit_way = AW'(w);
      end
      if (!inv_found && !valid[AW'(w)][req_idx]) begin
        inv_found = 1'b1;
        vic       = AW'(w);
      end
    end
    if (!inv_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age[AW'(w)][req_idx] == AW'(WAYS - 1)) vic = AW'(w);
      end
    end
  end

  // Datapath response: hits complete in the same cycle.
  always_comb begin
    dcif.dhit     = 1'b0;
    dcif.dmemload = '0;
    if (state == COMPARE && !dcif.halt && req && hit_any) begin
      dcif.dhit     = 1'b1;
      dcif.dmemload = dcif.dmemWEN ? dcif.dmemstore : data[hit_way][req_idx][req_off];
    end
  end

  // Memory request decoded from the registered state, so a reset drops it at once.
  always_comb begin
    dcif.dREN   = 1'b0;
    dcif.dWEN   = 1'b0;
    dcif.daddr  = '0;
    dcif.dstore = '0;
    case (state)
      WB: begin
        dcif.dWEN   = 1'b1;
        dcif.daddr  = mk_addr(tags[vway][midx], midx, k);
        dcif.dstore = data[vway][midx][k];
      end
      ALLOC: begin
        dcif.dREN  = 1'b1;
        dcif.daddr = mk_addr(mtag, midx, k);
      end
      FLUSH_WB: begin
        dcif.dWEN   = 1'b1;
        dcif.daddr  = mk_addr(tags[fway][fset], fset, k);
        dcif.dstore = data[fway][fset][k];
      end
      FLUSH_CNT: begin
        dcif.dWEN   = 1'b1;
        dcif.daddr  = HITCNT_ADDR;
        dcif.dstore = hitcnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= COMPARE;
      k      <= '0;
      vway   <= '0;
      mtag   <= '0;
      midx   <= '0;
      fway   <= '0;
      fset   <= '0;
      miss   <= 1'b0;
      hitcnt <= '0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid[w][s] <= 1'b0;
          dirty[w][s] <= 1'b0;
          tags[w][s]  <= '0;
          age[w][s]   <= AW'(w);
          for (int b = 0; b < BLOCK_WORDS; b++) data[w][s][b] <= '0;
        end
      end
    end else begin
      case (state)
        COMPARE: begin
          if (dcif.halt) begin
            state <= FLUSH_SCAN;
            fway  <= '0;
            fset  <= '0;
          end else if (req) begin
            if (hit_any) begin
              if (dcif.dmemWEN) begin
                data[hit_way][req_idx][req_off] <= dcif.dmemstore;
                dirty[hit_way][req_idx]         <= 1'b1;
              end
              for (int w = 0; w < WAYS; w++) begin
                if (AW'(w) == hit_way)
                  age[w][req_idx] <= '0;
                else if (age[w][req_idx] < age[hit_way][req_idx])
                  age[w][req_idx] <= age[w][req_idx] + AW'(1);
              end
              // The hit that follows a fill belongs to the miss, not the count.
              if (!miss) hitcnt <= hitcnt + 32'd1;
              miss <= 1'b0;
            end else begin
              miss  <= 1'b1;
              vway  <= vic;
              mtag  <= req_tag;
              midx  <= req_idx;
              k     <= '0;
              state <= dirty[vic][req_idx] ? WB : ALLOC;
            end
          end
        end
        WB: begin
          if (!dcif.dwait) begin
            k <= last_k ? '0 : k + WW'(1);
            if (last_k) state <= ALLOC;
          end
        end
        ALLOC: begin
          if (!dcif.dwait) begin
            data[vway][midx][k] <= dcif.dload;
            k <= last_k ? '0 : k + WW'(1);
            if (last_k) begin
              valid[vway][midx] <= 1'b1;
              dirty[vway][midx] <= 1'b0;
              tags[vway][midx]  <= mtag;
              state             <= COMPARE;
            end
          end
        end
        FLUSH_SCAN: begin
          if (dirty[fway][fset]) begin
            k     <= '0;
            state <= FLUSH_WB;
          end else if (last_line) begin
            state <= FLUSH_CNT;
          end else begin
            fset <= fset + IW'(1);
            if (fset == IW'(SETS - 1)) fway <= fway + AW'(1);
          end
        end
        FLUSH_WB: begin
          if (!dcif.dwait) begin
            k <= last_k ? '0 : k + WW'(1);
            if (last_k) begin
              dirty[fway][fset] <= 1'b0;
              if (last_line) begin
                state <= FLUSH_CNT;
              end else begin
                state <= FLUSH_SCAN;
                fset  <= fset + IW'(1);
                if (fset == IW'(SETS - 1)) fway <= fway + AW'(1);
              end
            end
          end
        end
        FLUSH_CNT: if (!dcif.dwait) state <= DONE;
        default:   state <= DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench for dcache_nway (WAYS=2, SETS=8, BLOCK_WORDS=2).
// Memory model returns 0xAAAA0000 + address and inserts a programmable
// number of wait cycles per access; completed accesses are logged.
module tb_dcache_nway;
  logic CLK = 1'b0;
  logic nRST;
  logic tb_dwait = 1'b0;

  dcache_nway_if bus ();

  dcache_nway #(
    .WAYS(2), .SETS(8), .BLOCK_WORDS(2), .HITCNT_ADDR(32'h3100)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .dcif(bus)
  );

  always #5 CLK = ~CLK;

  assign bus.dload = 32'hAAAA0000 + bus.daddr;
  assign bus.dwait = tb_dwait;

  int n_tests = 0;
  int n_fail  = 0;
  int ws      = 0;
  int wcnt    = 0;
  int stab_err = 0;
  bit mid     = 1'b0;
  logic [31:0] p_addr, p_store;
  logic        p_ren;
  logic        lg_we[$];
  logic [31:0] lg_addr[$];
  logic [31:0] lg_data[$];

  // Memory model: decide wait/complete at the falling edge, log completions.
  always @(negedge CLK) begin
    if (nRST && (bus.dREN || bus.dWEN)) begin
      if (mid && (bus.daddr !== p_addr || bus.dstore !== p_store || bus.dREN !== p_ren))
        stab_err++;
      if (wcnt < ws) begin
        tb_dwait = 1'b1;
        wcnt++;
        mid     = 1'b1;
        p_addr  = bus.daddr;
        p_store = bus.dstore;
        p_ren   = bus.dREN;
      end else begin
        tb_dwait = 1'b0;
        wcnt     = 0;
        mid      = 1'b0;
        lg_we.push_back(bus.dWEN);
        lg_addr.push_back(bus.daddr);
        lg_data.push_back(bus.dWEN ? bus.dstore : bus.dload);
      end
    end else begin
      tb_dwait = 1'b0;
      wcnt     = 0;
      mid      = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic lg_clear();
    lg_we.delete();
    lg_addr.delete();
    lg_data.delete();
  endtask

  task automatic do_reset();
    nRST          = 1'b0;
    bus.halt      = 1'b0;
    bus.dmemREN   = 1'b0;
    bus.dmemWEN   = 1'b0;
    bus.dmemaddr  = '0;
    bus.dmemstore = '0;
    ws            = 0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    lg_clear();
  endtask

  // Issues one request from posedge+1; returns cycles until dhit (0 = timeout).
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                        output int cyc, output logic [31:0] ld);
    bus.dmemREN   = !we;
    bus.dmemWEN   = we;
    bus.dmemaddr  = a;
    bus.dmemstore = d;
    cyc = 0;
    ld  = '0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge CLK);
      if (bus.dhit) begin
        cyc = i;
        ld  = bus.dmemload;
        break;
      end
    end
    @(posedge CLK);
    #1;
    bus.dmemREN   = 1'b0;
    bus.dmemWEN   = 1'b0;
    bus.dmemaddr  = '0;
    bus.dmemstore = '0;
  endtask

  task automatic test_reset();
    nRST          = 1'b0;
    bus.halt      = 1'b0;
    bus.dmemREN   = 1'b1;
    bus.dmemWEN   = 1'b0;
    bus.dmemaddr  = 32'h0;
    bus.dmemstore = '0;
    @(negedge CLK);
    n_tests++; if (bus.dhit !== 1'b0) begin n_fail++; $display("FAIL rst_dhit: got %b want 0", bus.dhit); end
    n_tests++; if (bus.dmemload !== 32'h0) begin n_fail++; $display("FAIL rst_dmemload: got %h want 0", bus.dmemload); end
    n_tests++; if (bus.flushed !== 1'b0) begin n_fail++; $display("FAIL rst_flushed: got %b want 0", bus.flushed); end
    n_tests++; if ({bus.dREN, bus.dWEN} !== 2'b00) begin n_fail++; $display("FAIL rst_dren_dwen: got %b want 00", {bus.dREN, bus.dWEN}); end
    n_tests++; if ({bus.daddr, bus.dstore} !== 64'h0) begin n_fail++; $display("FAIL rst_daddr_dstore: got %h want 0", {bus.daddr, bus.dstore}); end
    do_reset();
  endtask

  task automatic test_read_miss();
    int cyc; logic [31:0] ld;
    do_reset();
    do_req(1'b0, 32'h0, 32'h0, cyc, ld);
    n_tests++; if (cyc !== 4) begin n_fail++; $display("FAIL t1_miss_cycles: got %0d want 4", cyc); end
    n_tests++; if (ld !== 32'hAAAA0000) begin n_fail++; $display("FAIL t1_miss_data: got %h want AAAA0000", ld); end
    n_tests++; if (lg_addr.size() !== 2) begin n_fail++; $display("FAIL t1_fill_count: got %0d want 2", lg_addr.size()); end
    if (lg_addr.size() == 2) begin
      n_tests++; if ({lg_we[0], lg_addr[0], lg_we[1], lg_addr[1]} !== {1'b0, 32'h0, 1'b0, 32'h4})
        begin n_fail++; $display("FAIL t1_fill_addrs: got %h %h want 0 4", lg_addr[0], lg_addr[1]); end
    end
    do_req(1'b0, 32'h4, 32'h0, cyc, ld);
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL t1_hit_cycles: got %0d want 1", cyc); end
    n_tests++; if (ld !== 32'hAAAA0004) begin n_fail++; $display("FAIL t1_hit_data: got %h want AAAA0004", ld); end
    n_tests++; if (lg_addr.size() !== 2) begin n_fail++; $display("FAIL t1_hit_no_mem: got %0d accesses want 2", lg_addr.size()); end
  endtask

  task automatic test_lru();
    int cyc; logic [31:0] ld;
    do_reset();
    do_req(1'b0, 32'h000, 32'h0, cyc, ld);
    do_req(1'b0, 32'h040, 32'h0, cyc, ld);
    n_tests++; if (cyc !== 4) begin n_fail++; $display("FAIL t2_way1_fill: got %0d cycles want 4", cyc); end
    do_req(1'b0, 32'h000, 32'h0, cyc, ld);
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL t2_rehit: got %0d cycles want 1", cyc); end
    lg_clear();
    do_req(1'b0, 32'h080, 32'h0, cyc, ld);
    n_tests++; if (cyc !== 4) begin n_fail++; $display("FAIL t2_evict_cycles: got %0d want 4", cyc); end
    n_tests++; if (ld !== 32'hAAAA0080) begin n_fail++; $display("FAIL t2_evict_data: got %h want AAAA0080", ld); end
    n_tests++; if (lg_addr.size() !== 2) begin n_fail++; $display("FAIL t2_evict_count: got %0d want 2", lg_addr.size()); end
    do_req(1'b0, 32'h000, 32'h0, cyc, ld);
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL t2_mru_kept: got %0d cycles want 1", cyc); end
    n_tests++; if (lg_addr.size() !== 2) begin n_fail++; $display("FAIL t2_mru_no_mem: got %0d want 2", lg_addr.size()); end
    do_req(1'b0, 32'h040, 32'h0, cyc, ld);
    n_tests++; if (cyc !== 4) begin n_fail++; $display("FAIL t2_lru_gone: got %0d cycles want 4", cyc); end
  endtask

  task automatic test_writeback();
    int cyc; logic [31:0] ld;
    logic        exp_we [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] exp_a  [4] = '{32'h0, 32'h4, 32'h80, 32'h84};
    logic [31:0] exp_d  [4] = '{32'hDEADBEEF, 32'hAAAA0004, 32'hAAAA0080, 32'hAAAA0084};
    do_reset();
    do_req(1'b1, 32'h0, 32'hDEADBEEF, cyc, ld);
    n_tests++; if (ld !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t3_write_echo: got %h want DEADBEEF", ld); end
    do_req(1'b0, 32'h040, 32'h0, cyc, ld);
    lg_clear();
    do_req(1'b0, 32'h080, 32'h0, cyc, ld);
    n_tests++; if (cyc !== 6) begin n_fail++; $display("FAIL t3_wb_cycles: got %0d want 6", cyc); end
    n_tests++; if (lg_addr.size() !== 4) begin n_fail++; $display("FAIL t3_wb_count: got %0d want 4", lg_addr.size()); end
    for (int i = 0; i < 4 && i < lg_addr.size(); i++) begin
      n_tests++;
      if ({lg_we[i], lg_addr[i], lg_data[i]} !== {exp_we[i], exp_a[i], exp_d[i]}) begin
        n_fail++;
        $display("FAIL t3_access%0d: got we=%b a=%h d=%h want we=%b a=%h d=%h",
                 i, lg_we[i], lg_addr[i], lg_data[i], exp_we[i], exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_wait_states();
    int cyc; logic [31:0] ld;
    do_reset();
    ws       = 3;
    stab_err = 0;
    do_req(1'b0, 32'h10, 32'h0, cyc, ld);
    n_tests++; if (cyc !== 10) begin n_fail++; $display("FAIL t4_wait_cycles: got %0d want 10", cyc); end
    n_tests++; if (ld !== 32'hAAAA0010) begin n_fail++; $display("FAIL t4_wait_data: got %h want AAAA0010", ld); end
    n_tests++; if (stab_err !== 0) begin n_fail++; $display("FAIL t4_stable: got %0d changes want 0", stab_err); end
    n_tests++; if (lg_addr.size() !== 2) begin n_fail++; $display("FAIL t4_count: got %0d want 2", lg_addr.size()); end
    ws = 0;
  endtask

  task automatic test_flush();
    int cyc; int sz; bit found; logic [31:0] ld;
    logic [31:0] exp_a [5] = '{32'h08, 32'h0C, 32'h28, 32'h2C, 32'h3100};
    logic [31:0] exp_d [5] = '{32'h11111111, 32'hAAAA000C, 32'h22222222, 32'h33333333, 32'h3};
    do_reset();
    do_req(1'b1, 32'h08, 32'h11111111, cyc, ld);
    do_req(1'b1, 32'h28, 32'h22222222, cyc, ld);
    do_req(1'b0, 32'h08, 32'h0, cyc, ld);
    n_tests++; if (ld !== 32'h11111111) begin n_fail++; $display("FAIL t5_readback: got %h want 11111111", ld); end
    do_req(1'b0, 32'h0C, 32'h0, cyc, ld);
    do_req(1'b1, 32'h2C, 32'h33333333, cyc, ld);
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL t5_write_hit: got %0d cycles want 1", cyc); end
    lg_clear();
    bus.halt = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (bus.flushed) begin found = 1'b1; break; end
    end
    n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL t5_flushed: got %b want 1", found); end
    n_tests++; if (lg_addr.size() !== 5) begin n_fail++; $display("FAIL t5_flush_count: got %0d want 5", lg_addr.size()); end
    for (int i = 0; i < 5 && i < lg_addr.size(); i++) begin
      n_tests++;
      if ({lg_we[i], lg_addr[i], lg_data[i]} !== {1'b1, exp_a[i], exp_d[i]}) begin
        n_fail++;
        $display("FAIL t5_flush%0d: got we=%b a=%h d=%h want we=1 a=%h d=%h",
                 i, lg_we[i], lg_addr[i], lg_data[i], exp_a[i], exp_d[i]);
      end
    end
    sz = lg_addr.size();
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h08;
    repeat (4) begin
      @(negedge CLK);
      n_tests++; if (bus.dhit !== 1'b0) begin n_fail++; $display("FAIL t5_done_dhit: got %b want 0", bus.dhit); end
    end
    n_tests++; if (bus.flushed !== 1'b1) begin n_fail++; $display("FAIL t5_flushed_held: got %b want 1", bus.flushed); end
    n_tests++; if (lg_addr.size() !== sz) begin n_fail++; $display("FAIL t5_quiet: got %0d accesses want %0d", lg_addr.size(), sz); end
    bus.dmemREN  = 1'b0;
    bus.dmemaddr = '0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset_mid_alloc();
    int cyc; logic [31:0] ld;
    do_reset();
    ws = 100;
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h0;
    repeat (2) @(negedge CLK);
    #1;
    n_tests++; if ({bus.dREN, bus.dwait} !== 2'b11) begin n_fail++; $display("FAIL t6_in_alloc: got dREN,dwait=%b want 11", {bus.dREN, bus.dwait}); end
    nRST = 1'b0;
    #1;
    n_tests++; if (bus.dREN !== 1'b0) begin n_fail++; $display("FAIL t6_abort_dren: got %b want 0", bus.dREN); end
    n_tests++; if (bus.daddr !== 32'h0) begin n_fail++; $display("FAIL t6_abort_daddr: got %h want 0", bus.daddr); end
    bus.dmemREN = 1'b0;
    ws = 0;
    @(posedge CLK);
    #1 nRST = 1'b1;
    lg_clear();
    do_req(1'b0, 32'h0, 32'h0, cyc, ld);
    n_tests++; if (cyc !== 4) begin n_fail++; $display("FAIL t6_miss_again: got %0d cycles want 4", cyc); end
    n_tests++; if (lg_addr.size() !== 2) begin n_fail++; $display("FAIL t6_refill: got %0d accesses want 2", lg_addr.size()); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic [31:0] ld;
    do_reset();
    do_req(1'b1, 32'h18, 32'h5A5A5A5A, cyc, ld);
    do_req(1'b0, 32'h1C, 32'h0, cyc, ld);
    n_tests++; if (ld !== 32'hAAAA001C) begin n_fail++; $display("FAIL bb_other_word: got %h want AAAA001C", ld); end
    do_req(1'b0, 32'h18, 32'h0, cyc, ld);
    n_tests++; if (ld !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL bb_written_word: got %h want 5A5A5A5A", ld); end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_lru();
    test_writeback();
    test_wait_states();
    test_flush();
    test_reset_mid_alloc();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
